pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MC_LATENCY, default 4, SHALL set the EX multicycle-operation duration in cycles; legal range 2..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 rs1_id, rs2_id  input  5 each  SHALL carry the source registers of the instruction in ID.
REQ-005 use_rs1, use_rs2  input  1 each  SHALL flag that the ID instruction actually reads rs1 / rs2.
REQ-006 rd_ex  input  5  SHALL carry the destination register of the instruction in EX.
REQ-007 memread_ex  input  1  SHALL flag that the EX instruction is a load.
REQ-008 branch_taken_ex  input  1  SHALL flag a resolved taken branch or jump in EX.
REQ-009 mc_start_ex  input  1  SHALL flag that a multicycle operation starts in EX this cycle.
REQ-010 pc_write  output  1  SHALL enable the PC update.
REQ-011 if_id_write  output  1  SHALL enable the IF/ID register load.
REQ-012 if_id_flush  output  1  SHALL clear the IF/ID register to a NOP.
REQ-013 id_ex_write  output  1  SHALL enable the ID/EX register load; 0 holds EX.
REQ-014 id_ex_bubble  output  1  SHALL force the ID/EX RegWrite and ALU-control fields to 0 on load.
REQ-015 mc_busy  output  1  SHALL be high while in state MC_BUSY.
REQ-016 mc_done  output  1  SHALL pulse for one cycle in the last stall cycle of a multicycle operation.

Function
REQ-017 States SHALL be RUN and MC_BUSY, with a 4-bit down-counter mc_cnt.
REQ-018 Default outputs SHALL be pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=0, id_ex_bubble=0, mc_done=0.
REQ-019 Load-use hazard SHALL be detected when memread_ex=1, rd_ex!=0, and (use_rs1 and rs1_id==rd_ex, or use_rs2 and rs2_id==rd_ex).
REQ-020 RUN priority SHALL be branch_taken_ex > mc_start_ex > load-use.
REQ-021 RUN with branch_taken_ex SHALL assert if_id_flush=1 and id_ex_bubble=1 in the same cycle, keep pc_write=1, and stay in RUN.
REQ-022 RUN with mc_start_ex SHALL assert pc_write=0, if_id_write=0 and id_ex_write=0 in the same cycle, load mc_cnt=MC_LATENCY-2, and go to MC_BUSY.
REQ-023 RUN with load-use SHALL assert pc_write=0, if_id_write=0 and id_ex_bubble=1 in the same cycle for exactly one cycle, and stay in RUN.
REQ-024 MC_BUSY SHALL assert pc_write=0, if_id_write=0, id_ex_write=0 and mc_busy=1, and decrement mc_cnt each cycle.
REQ-025 MC_BUSY with mc_cnt==0 SHALL assert mc_done=1 and return to RUN on the next edge; total stall is exactly MC_LATENCY cycles including the mc_start_ex cycle.
REQ-026 In MC_BUSY, branch_taken_ex, mc_start_ex and load-use SHALL be ignored, because EX is frozen.
REQ-027 rd_ex==0 SHALL never produce a load-use stall.

Reset
REQ-028 rst=1 SHALL immediately force state=RUN and mc_cnt=0, with outputs at the REQ-018 defaults and mc_busy=0, including when rst asserts mid-MC_BUSY.
REQ-029 After rst deasserts, the first clk edge SHALL evaluate from RUN.

Configuration
REQ-030 With macro HAZ_PERF_CNT_EN defined, the block SHALL add output stall_cycles[15:0]: it increments on every cycle with pc_write=0, saturates at 0xFFFF, and is cleared by rst.
REQ-031 Without HAZ_PERF_CNT_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Load-use: memread_ex=1, rd_ex=5, rs1_id=5, use_rs1=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle, then defaults.
REQ-033 x0 load: memread_ex=1, rd_ex=0, rs1_id=0, use_rs1=1 -> no stall; also rs2_id match with use_rs2=0 -> no stall.
REQ-034 Branch with simultaneous load-use -> if_id_flush=1, id_ex_bubble=1, pc_write=1 (branch wins).
REQ-035 MC_LATENCY=4, mc_start_ex pulse at cycle N -> id_ex_write=0 during cycles N..N+3, mc_busy=1 during N+1..N+3, mc_done=1 at N+3, RUN at N+4; branch_taken_ex=1 at N+2 is ignored.
REQ-036 rst asserted at N+2 of REQ-035 -> outputs return to defaults asynchronously, mc_busy=0, no mc_done.
REQ-037 HAZ_PERF_CNT_EN defined: one load-use stall plus one MC_LATENCY=4 operation -> stall_cycles=5; preload near 0xFFFF -> count holds at 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and multicycle EX freeze.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] rd_ex,
    input  logic       memread_ex,
    input  logic       branch_taken_ex,
    input  logic       mc_start_ex,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_bubble,
    output logic       mc_busy,
    output logic       mc_done
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    // The mc_start_ex cycle is the first stall cycle and the mc_cnt==0 cycle the last.
    localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 2);

    state_t     state_q, state_d;
    logic [3:0] mc_cnt_q, mc_cnt_d;
    logic       load_use;

    assign load_use = memread_ex && (rd_ex != 5'd0) &&
                      ((use_rs1 && (rs1_id == rd_ex)) ||
                       (use_rs2 && (rs2_id == rd_ex)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // Outputs are gated by rst so the defaults appear as soon as reset asserts.
    always_comb begin
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        mc_busy      = 1'b0;
        mc_done      = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (branch_taken_ex) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (mc_start_ex) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_write = 1'b0;
                        mc_cnt_d    = MC_LOAD;
                        state_d     = MC_BUSY;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                MC_BUSY: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_write = 1'b0;
                    mc_busy     = 1'b1;
                    if (mc_cnt_q == 4'd0) begin
                        mc_done = 1'b1;
                        state_d = RUN;
                    end else begin
                        mc_cnt_d = mc_cnt_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MC_LATENCY=4).
// Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, mc_busy, mc_done}.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       use_rs1, use_rs2, memread_ex, branch_taken_ex, mc_start_ex;
    logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, mc_busy, mc_done;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] DEF  = 7'b1101000;
    localparam logic [6:0] LU   = 7'b0001100;
    localparam logic [6:0] BR   = 7'b1111100;
    localparam logic [6:0] MCS  = 7'b0000000;
    localparam logic [6:0] BUSY = 7'b0000010;
    localparam logic [6:0] DONE = 7'b0000011;

    pipe_hazard_ctrl #(.MC_LATENCY(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .use_rs1         (use_rs1),
        .use_rs2         (use_rs2),
        .rd_ex           (rd_ex),
        .memread_ex      (memread_ex),
        .branch_taken_ex (branch_taken_ex),
        .mc_start_ex     (mc_start_ex),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_write     (id_ex_write),
        .id_ex_bubble    (id_ex_bubble),
        .mc_busy         (mc_busy),
        .mc_done         (mc_done)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] outVec();
        return {9'd0, pc_write, if_id_write, if_id_flush, id_ex_write,
                id_ex_bubble, mc_busy, mc_done};
    endfunction

    // Drive one cycle of ID/EX inputs just after the edge, then settle at the falling edge.
    task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic br, input logic mc);
        @(posedge clk);
        #1;
        rs1_id = r1; rs2_id = r2; use_rs1 = u1; use_rs2 = u2;
        rd_ex = rd; memread_ex = mr; branch_taken_ex = br; mc_start_ex = mc;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        use_rs1 = 0; use_rs2 = 0; memread_ex = 0; branch_taken_ex = 0; mc_start_ex = 0;
        @(negedge clk);
        checkOutput("reset_defaults", outVec(), {9'd0, DEF});
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(5, 0, 1, 0, 5, 1, 0, 0);
        checkOutput("loaduse_rs1", outVec(), {9'd0, LU});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("loaduse_release", outVec(), {9'd0, DEF});
        applyStimulus(3, 7, 1, 1, 7, 1, 0, 0);
        checkOutput("loaduse_rs2", outVec(), {9'd0, LU});
        applyStimulus(5, 0, 1, 0, 5, 0, 0, 0);
        checkOutput("no_load_no_stall", outVec(), {9'd0, DEF});
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
        checkOutput("x0_load", outVec(), {9'd0, DEF});
        applyStimulus(1, 9, 1, 0, 9, 1, 0, 0);
        checkOutput("rs2_unused", outVec(), {9'd0, DEF});
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 0);
        checkOutput("branch_wins", outVec(), {9'd0, BR});
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 1);
        checkOutput("branch_over_mc", outVec(), {9'd0, BR});
        applyStimulus(5, 0, 1, 0, 5, 1, 0, 1);
        checkOutput("mc_over_loaduse", outVec(), {9'd0, MCS});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mc_n1_busy", outVec(), {9'd0, BUSY});
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 1);
        checkOutput("mc_n2_ignore", outVec(), {9'd0, BUSY});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mc_n3_done", outVec(), {9'd0, DONE});
        applyStimulus(5, 0, 1, 0, 5, 1, 0, 0);
        checkOutput("mc_n4_run", outVec(), {9'd0, LU});

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("rst_mc_start", outVec(), {9'd0, MCS});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_mc_busy", outVec(), {9'd0, BUSY});
        @(posedge clk);
        #1 rst = 1'b1;
        #1 checkOutput("rst_async", outVec(), {9'd0, DEF});
        @(negedge clk);
        checkOutput("rst_hold", outVec(), {9'd0, DEF});
        @(negedge clk);
        checkOutput("rst_no_done", outVec(), {9'd0, DEF});
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("post_rst_start", outVec(), {9'd0, MCS});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_busy1", outVec(), {9'd0, BUSY});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_busy2", outVec(), {9'd0, BUSY});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_done", outVec(), {9'd0, DONE});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_run", outVec(), {9'd0, DEF});

`ifdef HAZ_PERF_CNT_EN
        @(posedge clk);
        #1 rst = 1'b1;
        #1 checkOutput("perf_reset", stall_cycles, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(5, 0, 1, 0, 5, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("perf_count5", stall_cycles, 16'd5);
        applyStimulus(5, 0, 1, 0, 5, 1, 0, 0);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        checkOutput("perf_saturate", stall_cycles, 16'hFFFF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
